// File: rtl/dm_bank.sv
// rtl/dm_bank.sv - byte-addressable 32-bit data memory bank with lane-aware load/store
// Optional feature macro: DM_RDREG_EN (defined: registered read, latency 1; undefined: combinational read)
module dm_bank #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W+1:0] addr,
  input  logic [1:0]        mode,
  input  logic              we,
  input  logic              re,
  input  logic              sext,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              err,
  output logic [CNT_W-1:0]  wcnt
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_BYTE = 2'b10;

  logic [31:0]       r_mem [DEPTH];
  logic [CNT_W-1:0]  r_wcnt;

  logic [ADDR_W-1:0] w_widx;
  logic              w_bad;
  logic              w_err;
  logic              w_commit;
  logic [31:0]       w_word;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;
  logic [31:0]       w_load;
  logic [31:0]       w_wmask;
  logic [31:0]       w_wval;

  assign w_widx   = addr[ADDR_W+1:2];
  assign w_commit = we & ~w_err;
  assign err      = w_err;
  assign wcnt     = r_wcnt;

  // Misalignment / illegal-size detection, only meaningful while a request is present
  always_comb begin
    w_bad = (mode == 2'b11)
          | ((mode == MODE_WORD) & (addr[1:0] != 2'b00))
          | ((mode == MODE_HALF) & addr[0]);
    w_err = (we | re) & w_bad;
  end

  // Load extraction: select the addressed lane and extend it; faulting reads return zero
  always_comb begin
    w_word = r_mem[w_widx];
    w_half = addr[1] ? w_word[31:16] : w_word[15:0];
    case (addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    case (mode)
      MODE_WORD: w_load = w_word;
      MODE_HALF: w_load = {{16{sext & w_half[15]}}, w_half};
      MODE_BYTE: w_load = {{24{sext & w_byte[7]}}, w_byte};
      default:   w_load = 32'h0;
    endcase
    if (w_err) begin
      w_load = 32'h0;
    end
  end

  // Store lane mask and replicated data so only the addressed lane(s) change
  always_comb begin
    w_wmask = 32'h0;
    w_wval  = wdata;
    case (mode)
      MODE_WORD: begin
        w_wmask = 32'hFFFF_FFFF;
        w_wval  = wdata;
      end
      MODE_HALF: begin
        w_wmask = addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_wval  = {wdata[15:0], wdata[15:0]};
      end
      MODE_BYTE: begin
        w_wmask = 32'h0000_00FF << {addr[1:0], 3'b000};
        w_wval  = {4{wdata[7:0]}};
      end
      default: begin
        w_wmask = 32'h0;
        w_wval  = wdata;
      end
    endcase
  end

  // Memory array: cleared on reset, masked read-modify-write on a committed store
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_commit) begin
      r_mem[w_widx] <= (r_mem[w_widx] & ~w_wmask) | (w_wval & w_wmask);
    end
  end

  // Committed-write counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wcnt <= '0;
    end else if (w_commit && (r_wcnt != {CNT_W{1'b1}})) begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

`ifdef DM_RDREG_EN
  logic        r_rvalid;
  logic [31:0] r_rdata;

  // Registered read port; memory is sampled before the same-edge store lands (read-first)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_rvalid <= re;
      r_rdata  <= re ? w_load : 32'h0;
    end
  end

  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
`else
  // Combinational read port; array contents before the edge give read-first ordering
  assign rvalid = re & reset_n;
  assign rdata  = rvalid ? w_load : 32'h0;
`endif

endmodule

// File: tb/tb_dm_bank.sv
// tb/tb_dm_bank.sv - self-checking bench for dm_bank, table vectors plus read scoreboard
module tb_dm_bank;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [1:0]  mode;
    logic        we;
    logic        re;
    logic        sext;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_wcnt;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [11:0] addr;
  logic [1:0]  mode;
  logic        we;
  logic        re;
  logic        sext;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic [15:0] wcnt;

  logic        reset_n2;
  logic [5:0]  addr2;
  logic        we2;
  logic        re2;
  logic [31:0] wdata2;
  logic [31:0] rdata2;
  logic        rvalid2;
  logic        err2;
  logic [1:0]  wcnt2;

  int checks;
  int failures;

  logic [31:0] sb_q[$];
  vec_t        tbl[$];

  dm_bank #(.ADDR_W(10), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .mode(mode), .we(we), .re(re),
    .sext(sext), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .err(err), .wcnt(wcnt)
  );

  dm_bank #(.ADDR_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n2), .addr(addr2), .mode(2'b00), .we(we2), .re(re2),
    .sext(1'b0), .wdata(wdata2), .rdata(rdata2), .rvalid(rvalid2), .err(err2), .wcnt(wcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [11:0] a, input logic [1:0] m,
                              input logic w, input logic r, input logic s, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee, input logic [15:0] ec);
    vec_t v;
    v.name = name; v.addr = a; v.mode = m; v.we = w; v.re = r; v.sext = s;
    v.wdata = wd; v.exp_rdata = er; v.exp_err = ee; v.exp_wcnt = ec;
    return v;
  endfunction

  task automatic check_read(input vec_t v);
    chk({v.name, " rvalid"}, {31'h0, rvalid}, {31'h0, v.re});
    if (v.re) begin
      if (sb_q.size() == 0) begin
        chk({v.name, " scoreboard underflow"}, 32'h1, 32'h0);
      end else begin
        chk({v.name, " rdata"}, rdata, sb_q.pop_front());
      end
    end else begin
      chk({v.name, " idle rdata"}, rdata, 32'h0);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    addr = v.addr; mode = v.mode; we = v.we; re = v.re; sext = v.sext; wdata = v.wdata;
    if (v.re) sb_q.push_back(v.exp_rdata);
    #2;
    chk({v.name, " err"}, {31'h0, err}, {31'h0, v.exp_err});
`ifndef DM_RDREG_EN
    check_read(v);
`endif
    @(posedge clk);
    #1;
`ifdef DM_RDREG_EN
    check_read(v);
`endif
    chk({v.name, " wcnt"}, {16'h0, wcnt}, {16'h0, v.exp_wcnt});
  endtask

  task automatic step2(input string name, input logic [5:0] a, input logic w, input logic r,
                       input logic [31:0] wd, input logic [31:0] er, input logic [1:0] ec);
    @(negedge clk);
    addr2 = a; we2 = w; re2 = r; wdata2 = wd;
    #2;
`ifndef DM_RDREG_EN
    if (r) chk({name, " rdata"}, rdata2, er);
`endif
    @(posedge clk);
    #1;
`ifdef DM_RDREG_EN
    if (r) chk({name, " rdata"}, rdata2, er);
`endif
    chk({name, " wcnt"}, {30'h0, wcnt2}, {30'h0, ec});
  endtask

  task automatic idle_inputs();
    we = 1'b0; re = 1'b0; addr = '0; mode = 2'b00; sext = 1'b0; wdata = '0;
    we2 = 1'b0; re2 = 1'b0; addr2 = '0; wdata2 = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    reset_n2 = 1'b0;
    idle_inputs();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset rvalid", {31'h0, rvalid}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset wcnt", {16'h0, wcnt}, 32'h0);
    chk("reset err", {31'h0, err}, 32'h0);
    chk("reset wcnt2", {30'h0, wcnt2}, 32'h0);
    @(negedge clk);
    reset_n  = 1'b1;
    reset_n2 = 1'b1;

    //            name         addr    md     we    re    sx    wdata          rdata          err   wcnt
    tbl.push_back(mk("sw 004",  12'h004, 2'b00, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0,        1'b0, 16'd1));
    tbl.push_back(mk("lw 004",  12'h004, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        32'h12345678, 1'b0, 16'd1));
    tbl.push_back(mk("sb 006",  12'h006, 2'b10, 1'b1, 1'b0, 1'b0, 32'h000000AB, 32'h0,        1'b0, 16'd2));
    tbl.push_back(mk("lbu 006", 12'h006, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        32'h000000AB, 1'b0, 16'd2));
    tbl.push_back(mk("lb 006",  12'h006, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0,        32'hFFFFFFAB, 1'b0, 16'd2));
    tbl.push_back(mk("lw 004b", 12'h004, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        32'h12AB5678, 1'b0, 16'd2));
    tbl.push_back(mk("sh 00A",  12'h00A, 2'b01, 1'b1, 1'b0, 1'b0, 32'h00008001, 32'h0,        1'b0, 16'd3));
    tbl.push_back(mk("lh 00A",  12'h00A, 2'b01, 1'b0, 1'b1, 1'b1, 32'h0,        32'hFFFF8001, 1'b0, 16'd3));
    tbl.push_back(mk("lhu 00A", 12'h00A, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00008001, 1'b0, 16'd3));
    tbl.push_back(mk("lw 008",  12'h008, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        32'h80010000, 1'b0, 16'd3));
    tbl.push_back(mk("lh 009",  12'h009, 2'b01, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        1'b1, 16'd3));
    tbl.push_back(mk("sw 002",  12'h002, 2'b00, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1, 16'd3));
    tbl.push_back(mk("lw 004c", 12'h004, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        32'h12AB5678, 1'b0, 16'd3));
    tbl.push_back(mk("lw 000",  12'h000, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 16'd3));
    tbl.push_back(mk("sw+lw 010", 12'h010, 2'b00, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0,      1'b0, 16'd4));
    tbl.push_back(mk("lw 010",  12'h010, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 16'd4));
    tbl.push_back(mk("ill 000", 12'h000, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 16'd4));
    tbl.push_back(mk("sb 007",  12'h007, 2'b10, 1'b1, 1'b0, 1'b0, 32'h123456CD, 32'h0,        1'b0, 16'd5));
    tbl.push_back(mk("lb 007",  12'h007, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0,        32'hFFFFFFCD, 1'b0, 16'd5));
    tbl.push_back(mk("lhu 006", 12'h006, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000CDAB, 1'b0, 16'd5));
    tbl.push_back(mk("lh 004",  12'h004, 2'b01, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00005678, 1'b0, 16'd5));
    tbl.push_back(mk("lbu 005", 12'h005, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00000056, 1'b0, 16'd5));
    tbl.push_back(mk("idle",    12'h004, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 16'd5));

    foreach (tbl[i]) step(tbl[i]);

    // reset during a read: pending result discarded, memory and counter cleared
    @(negedge clk);
    reset_n = 1'b0; re = 1'b1; we = 1'b0; addr = 12'h004; mode = 2'b00; sext = 1'b0;
    #2;
    chk("rst-rd comb rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst-rd comb rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("rst-rd rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst-rd rdata", rdata, 32'h0);
    chk("rst-rd wcnt", {16'h0, wcnt}, 32'h0);
    @(negedge clk);
    re = 1'b0;
    reset_n = 1'b1;

    step(mk("post-rst lw 004", 12'h004, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,     32'h0,        1'b0, 16'd0));
    step(mk("post-rst lw 010", 12'h010, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,     32'h0,        1'b0, 16'd0));
    step(mk("post-rst sw 020", 12'h020, 2'b00, 1'b1, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h0,    1'b0, 16'd1));
    step(mk("post-rst lw 020", 12'h020, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,     32'hA5A5_0F0F, 1'b0, 16'd1));
    step(mk("top word sw", 12'hFFC, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0,        1'b0, 16'd2));
    step(mk("top word lh", 12'hFFE, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,        32'h00000BAD, 1'b0, 16'd2));
    step(mk("idle2",       12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 16'd2));

    chk("scoreboard drained", sb_q.size(), 32'h0);

    // saturating counter on the narrow instance
    step2("c2 w0",  6'h00, 1'b1, 1'b0, 32'h11111111, 32'h0, 2'd1);
    step2("c2 w1",  6'h04, 1'b1, 1'b0, 32'h22222222, 32'h0, 2'd2);
    step2("c2 w2",  6'h08, 1'b1, 1'b0, 32'h33333333, 32'h0, 2'd3);
    step2("c2 w3",  6'h0C, 1'b1, 1'b0, 32'h44444444, 32'h0, 2'd3);
    step2("c2 w4",  6'h10, 1'b1, 1'b0, 32'h55555555, 32'h0, 2'd3);
    step2("c2 rd",  6'h0C, 1'b0, 1'b1, 32'h0, 32'h44444444, 2'd3);
    @(negedge clk);
    we2 = 1'b0; re2 = 1'b0;
    reset_n2 = 1'b0;
    @(posedge clk);
    #1;
    chk("c2 reset wcnt", {30'h0, wcnt2}, 32'h0);
    @(negedge clk);
    reset_n2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step2($sformatf("c2 clr rd %0d", k), 6'(k * 4), 1'b0, 1'b1, 32'h0, 32'h0, 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
